// File: rtl/lcd_pkg.sv
// Shared constants and state encoding for the HD44780 power-up/redraw sequencer.
package lcd_pkg;

  localparam logic [7:0] LCD_FUNC_SET = 8'h38;
  localparam logic [7:0] LCD_DISP_ON  = 8'h0C;
  localparam logic [7:0] LCD_CLEAR    = 8'h01;
  localparam logic [7:0] LCD_ENTRY    = 8'h06;
  localparam logic [7:0] LCD_LINE0    = 8'h80;
  localparam logic [7:0] LCD_LINE1    = 8'hC0;

  localparam logic [7:0] CHAR_SPACE   = 8'h20;

  localparam logic [5:0] CLEAR_STEP   = 6'd2;
  localparam logic [5:0] ENTRY_STEP   = 6'd3;
  localparam logic [5:0] REFRESH_STEP = 6'd4;
  localparam logic [5:0] LINE1_STEP   = 6'd21;
  localparam logic [5:0] LAST_STEP    = 6'd37;

  typedef enum logic [2:0] {
    POWERUP,
    LOAD,
    ISSUE,
    WAIT_LO,
    WAIT_HI,
    DELAY,
    FIN,
    IDLE
  } seq_state_t;

endpackage

// File: rtl/lcd_char_buf.sv
// 2x16 character shadow buffer: synchronous write, combinational read,
// cleared to spaces by reset.
module lcd_char_buf
  import lcd_pkg::*;
(
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic       wr_en,
  input  logic [4:0] wr_addr,
  input  logic [7:0] wr_char,
  input  logic [4:0] rd_addr,
  output logic [7:0] rd_char
);

  logic [7:0] mem [32];

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      for (int i = 0; i < 32; i++) mem[i] <= CHAR_SPACE;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_char;
    end
  end

  // A write landing in the same cycle as a read returns the old byte.
  assign rd_char = mem[rd_addr];

endmodule

// File: rtl/lcd_seq.sv
// HD44780 sequencer: runs power-up init, then redraws the shadow buffer through
// LCD_CTRL's START/DONE handshake, one command or character per transaction.
module lcd_seq
  import lcd_pkg::*;
#(
  parameter int INIT_WAIT = 20,
  parameter int CLR_WAIT  = 2
) (
  input  logic       CLK1K,
  input  logic       RSTN,
  input  logic       WR_EN,
  input  logic [4:0] WR_ADDR,
  input  logic [7:0] WR_CHAR,
  input  logic       REFRESH,
  output logic       READY,
  output logic       FRAME_DONE,
  output logic [7:0] LCD_DIN,
  output logic       LCD_RSO,
  output logic       LCD_START,
  input  logic       LCD_DONE
);

  localparam logic [15:0] INIT_LAST = (INIT_WAIT > 1) ? 16'(INIT_WAIT - 1) : 16'd0;
  localparam logic [15:0] CLR_LAST  = (CLR_WAIT > 1) ? 16'(CLR_WAIT - 1) : 16'd0;

  seq_state_t  state;
  logic [5:0]  step;
  logic [15:0] wait_cnt;
  logic        pending;
  logic [4:0]  rd_addr;
  logic [7:0]  rd_char;

  // Line-1 characters sit one step later because of the 0xC0 address command.
  function automatic logic [4:0] step_addr(input logic [5:0] s);
    if (s > LINE1_STEP) return 5'(s - 6'd6);
    else                return 5'(s - 6'd5);
  endfunction

  function automatic logic [8:0] step_byte(input logic [5:0] s, input logic [7:0] ch);
    case (s)
      6'd0:         return {1'b0, LCD_FUNC_SET};
      6'd1:         return {1'b0, LCD_DISP_ON};
      CLEAR_STEP:   return {1'b0, LCD_CLEAR};
      ENTRY_STEP:   return {1'b0, LCD_ENTRY};
      REFRESH_STEP: return {1'b0, LCD_LINE0};
      LINE1_STEP:   return {1'b0, LCD_LINE1};
      default:      return {1'b1, ch};
    endcase
  endfunction

  assign rd_addr = step_addr(step);

  lcd_char_buf u_buf (
    .CLK1K   (CLK1K),
    .RSTN    (RSTN),
    .wr_en   (WR_EN),
    .wr_addr (WR_ADDR),
    .wr_char (WR_CHAR),
    .rd_addr (rd_addr),
    .rd_char (rd_char)
  );

  always_ff @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      state      <= POWERUP;
      step       <= '0;
      wait_cnt   <= '0;
      pending    <= 1'b0;
      LCD_DIN    <= '0;
      LCD_RSO    <= 1'b0;
      LCD_START  <= 1'b0;
      READY      <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      // Requests arriving while busy merge into a single pending redraw;
      // the branches that start a redraw clear it afterwards.
      if (REFRESH && state != IDLE) pending <= 1'b1;

      case (state)
        POWERUP: begin
          if (wait_cnt >= INIT_LAST) begin
            wait_cnt <= '0;
            state    <= LOAD;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        LOAD: begin
          {LCD_RSO, LCD_DIN} <= step_byte(step, rd_char);
          LCD_START          <= 1'b1;
          state              <= ISSUE;
        end
        ISSUE: begin
          LCD_START <= 1'b0;
          state     <= WAIT_LO;
        end
        WAIT_LO: begin
          if (!LCD_DONE) state <= WAIT_HI;
        end
        WAIT_HI: begin
          if (LCD_DONE) begin
            if (step == CLEAR_STEP) begin
              wait_cnt <= '0;
              state    <= DELAY;
            end else if (step == LAST_STEP) begin
              FRAME_DONE <= 1'b1;
              state      <= FIN;
            end else begin
              step  <= step + 6'd1;
              state <= LOAD;
            end
          end
        end
        DELAY: begin
          if (wait_cnt >= CLR_LAST) begin
            wait_cnt <= '0;
            step     <= ENTRY_STEP;
            state    <= LOAD;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        FIN: begin
          FRAME_DONE <= 1'b0;
          if (pending) begin
            pending <= 1'b0;
            step    <= REFRESH_STEP;
            state   <= LOAD;
          end else begin
            READY <= 1'b1;
            state <= IDLE;
          end
        end
        IDLE: begin
          if (REFRESH || pending) begin
            pending <= 1'b0;
            READY   <= 1'b0;
            step    <= REFRESH_STEP;
            state   <= LOAD;
          end
        end
        default: state <= POWERUP;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_seq.sv
// Self-checking bench for lcd_seq: an LCD_CTRL handshake model logs every byte,
// and each test compares the log against frames built from a shadow-buffer model.
module tb_lcd_seq;

  localparam int INIT_WAIT = 20;
  localparam int CLR_WAIT  = 2;
  localparam int BOUND     = 4000;

  logic       CLK1K = 1'b0;
  logic       RSTN;
  logic       WR_EN;
  logic [4:0] WR_ADDR;
  logic [7:0] WR_CHAR;
  logic       REFRESH;
  logic       READY;
  logic       FRAME_DONE;
  logic [7:0] LCD_DIN;
  logic       LCD_RSO;
  logic       LCD_START;
  logic       LCD_DONE;

  int checks   = 0;
  int failures = 0;

  logic [7:0] ref_buf [32];
  logic [8:0] exp_q [$];

  // Controller model configuration and observations
  int lat_min = 4, lat_max = 4, stale_cycles = 0;
  int phase = 0, phase_cnt = 0;
  logic [8:0] held = '0;
  logic start_prev;
  int cyc = 0, start_count = 0, start_viol = 0, din_viol = 0, fd_count = 0, overlap = 0;
  logic [8:0] byte_q [$];
  int time_q [$];

  lcd_seq #(.INIT_WAIT(INIT_WAIT), .CLR_WAIT(CLR_WAIT)) dut (
    .CLK1K      (CLK1K),
    .RSTN       (RSTN),
    .WR_EN      (WR_EN),
    .WR_ADDR    (WR_ADDR),
    .WR_CHAR    (WR_CHAR),
    .REFRESH    (REFRESH),
    .READY      (READY),
    .FRAME_DONE (FRAME_DONE),
    .LCD_DIN    (LCD_DIN),
    .LCD_RSO    (LCD_RSO),
    .LCD_START  (LCD_START),
    .LCD_DONE   (LCD_DONE)
  );

  always #5 CLK1K = ~CLK1K;

  // LCD_CTRL model: optionally keeps the stale DONE=1 for a while, then
  // drops DONE for a (possibly random) busy time and raises it again.
  always @(posedge CLK1K or negedge RSTN) begin
    if (!RSTN) begin
      LCD_DONE   <= 1'b0;
      phase      <= 0;
      phase_cnt  <= 0;
      start_prev <= 1'b0;
    end else begin
      cyc        <= cyc + 1;
      start_prev <= LCD_START;
      if (LCD_START && (start_prev || phase != 0)) start_viol <= start_viol + 1;
      if (phase != 0 && {LCD_RSO, LCD_DIN} !== held) din_viol <= din_viol + 1;
      case (phase)
        0: if (LCD_START) begin
          byte_q.push_back({LCD_RSO, LCD_DIN});
          time_q.push_back(cyc);
          start_count <= start_count + 1;
          held        <= {LCD_RSO, LCD_DIN};
          if (stale_cycles > 0) begin
            phase     <= 1;
            phase_cnt <= stale_cycles;
          end else begin
            LCD_DONE  <= 1'b0;
            phase     <= 2;
            phase_cnt <= $urandom_range(lat_max, lat_min);
          end
        end
        1: if (phase_cnt <= 1) begin
          LCD_DONE  <= 1'b0;
          phase     <= 2;
          phase_cnt <= $urandom_range(lat_max, lat_min);
        end else begin
          phase_cnt <= phase_cnt - 1;
        end
        2: if (phase_cnt <= 1) begin
          LCD_DONE <= 1'b1;
          phase    <= 0;
        end else begin
          phase_cnt <= phase_cnt - 1;
        end
        default: phase <= 0;
      endcase
    end
  end

  always @(negedge CLK1K) begin
    if (FRAME_DONE) fd_count <= fd_count + 1;
    if (FRAME_DONE && READY) overlap <= overlap + 1;
  end

  // A redraw as the panel should see it: line-0 address, 16 chars, line-1 address, 16 chars.
  function automatic void add_frame();
    exp_q.push_back({1'b0, 8'h80});
    for (int i = 0; i < 16; i++) exp_q.push_back({1'b1, ref_buf[i]});
    exp_q.push_back({1'b0, 8'hC0});
    for (int i = 16; i < 32; i++) exp_q.push_back({1'b1, ref_buf[i]});
  endfunction

  task automatic wait_frames(input int n, output bit ok);
    int target;
    target = fd_count + n;
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge CLK1K);
      if (fd_count >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_starts(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < BOUND; i++) begin
      @(negedge CLK1K);
      if (start_count >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic host_write(input logic [4:0] addr, input logic [7:0] ch);
    @(negedge CLK1K);
    WR_EN = 1'b1; WR_ADDR = addr; WR_CHAR = ch;
    @(negedge CLK1K);
    WR_EN = 1'b0;
  endtask

  task automatic pulse_refresh();
    @(negedge CLK1K);
    REFRESH = 1'b1;
    @(negedge CLK1K);
    REFRESH = 1'b0;
  endtask

  task automatic random_writes(input int n);
    logic [4:0] a;
    logic [7:0] c;
    for (int i = 0; i < n; i++) begin
      a = 5'($urandom_range(31, 0));
      c = 8'($urandom_range(126, 33));
      host_write(a, c);
      ref_buf[a] = c;
    end
  endtask

  task automatic test_reset();
    RSTN = 1'b0; WR_EN = 1'b0; WR_ADDR = '0; WR_CHAR = '0; REFRESH = 1'b0;
    for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    repeat (3) @(negedge CLK1K);
    checks++;
    if ({LCD_DIN, LCD_RSO, LCD_START, READY, FRAME_DONE} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got din=%h rs=%b start=%b ready=%b fd=%b required all 0",
               LCD_DIN, LCD_RSO, LCD_START, READY, FRAME_DONE);
    end
  endtask

  // Releases reset (must be low on entry) and checks the full power-up sequence.
  task automatic test_init();
    int base, fd0, c0, g_clr, g_norm;
    bit ok;
    logic [7:0] cmds [4];
    cmds = '{8'h38, 8'h0C, 8'h01, 8'h06};
    lat_min = 4; lat_max = 4; stale_cycles = 0;
    exp_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, cmds[i]});
    add_frame();
    base = byte_q.size();
    fd0  = fd_count;
    @(negedge CLK1K);
    RSTN = 1'b1;
    c0 = cyc;
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL init_timeout: got no FRAME_DONE required one within %0d cycles", BOUND); end
    repeat (2) @(negedge CLK1K);
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL init_ready: got %b required 1", READY); end
    checks++;
    if (fd_count - fd0 != 1) begin failures++; $display("FAIL init_frame_done_count: got %0d required 1", fd_count - fd0); end
    checks++;
    if (time_q.size() <= base || time_q[base] - c0 != INIT_WAIT + 1) begin
      failures++;
      $display("FAIL init_first_start: got cycle %0d required %0d",
               (time_q.size() > base) ? time_q[base] - c0 : -1, INIT_WAIT + 1);
    end
    checks++;
    if (byte_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL init_byte_count: got %0d required %0d", byte_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= byte_q.size() || byte_q[base + i] !== exp_q[i]) begin
        failures++;
        $display("FAIL init_byte%0d: got rs_data=%h required %h", i,
                 (base + i < byte_q.size()) ? byte_q[base + i] : 9'h000, exp_q[i]);
      end
    end
    if (time_q.size() >= base + 4) begin
      g_norm = time_q[base + 1] - time_q[base];
      g_clr  = time_q[base + 3] - time_q[base + 2];
      checks++;
      if (g_clr - g_norm != CLR_WAIT) begin
        failures++; $display("FAIL init_clear_delay: got %0d extra cycles required %0d", g_clr - g_norm, CLR_WAIT);
      end
    end
  endtask

  task automatic test_write_refresh();
    int base, fd0;
    bit ok;
    lat_min = 2; lat_max = 6;
    random_writes(6);
    host_write(5'd0, 8'h41);  ref_buf[0]  = 8'h41;
    host_write(5'd31, 8'h5A); ref_buf[31] = 8'h5A;
    exp_q.delete();
    add_frame();
    base = byte_q.size();
    fd0  = fd_count;
    @(negedge CLK1K);
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL wr_ready_before: got %b required 1", READY); end
    REFRESH = 1'b1;
    @(negedge CLK1K);
    REFRESH = 1'b0;
    checks++;
    if (READY !== 1'b0) begin failures++; $display("FAIL wr_ready_drop: got %b required 0", READY); end
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL wr_timeout: got no FRAME_DONE required one"); end
    repeat (2) @(negedge CLK1K);
    checks++;
    if (fd_count - fd0 != 1 || byte_q.size() - base != exp_q.size()) begin
      failures++;
      $display("FAIL wr_counts: got frames=%0d bytes=%0d required 1 and %0d", fd_count - fd0, byte_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= byte_q.size() || byte_q[base + i] !== exp_q[i]) begin
        failures++;
        $display("FAIL wr_byte%0d: got rs_data=%h required %h", i,
                 (base + i < byte_q.size()) ? byte_q[base + i] : 9'h000, exp_q[i]);
      end
    end
  endtask

  task automatic test_pending();
    int base, fd0;
    bit ok;
    lat_min = 2; lat_max = 5;
    exp_q.delete();
    add_frame();
    add_frame();
    base = byte_q.size();
    fd0  = fd_count;
    pulse_refresh();
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(15, 3)) @(negedge CLK1K);
      pulse_refresh();
    end
    wait_frames(2, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL pend_timeout: got %0d frames required 2", fd_count - fd0); end
    repeat (60) @(negedge CLK1K);
    checks++;
    if (fd_count - fd0 != 2) begin failures++; $display("FAIL pend_frames: got %0d required 2", fd_count - fd0); end
    checks++;
    if (byte_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL pend_byte_count: got %0d required %0d", byte_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= byte_q.size() || byte_q[base + i] !== exp_q[i]) begin
        failures++;
        $display("FAIL pend_byte%0d: got rs_data=%h required %h", i,
                 (base + i < byte_q.size()) ? byte_q[base + i] : 9'h000, exp_q[i]);
      end
    end
    checks++;
    if (READY !== 1'b1) begin failures++; $display("FAIL pend_ready_after: got %b required 1", READY); end
    checks++;
    if (overlap != 0) begin failures++; $display("FAIL ready_fd_overlap: got %0d cycles required 0", overlap); end
  endtask

  task automatic test_collision();
    int base, s0;
    bit ok;
    logic [7:0] c30;
    lat_min = 4; lat_max = 4; stale_cycles = 0;
    host_write(5'd5, 8'h33); ref_buf[5] = 8'h33;
    c30 = 8'($urandom_range(126, 33));
    if (c30 == ref_buf[30]) c30 = c30 ^ 8'h01;
    exp_q.delete();
    ref_buf[30] = c30;
    add_frame();
    ref_buf[5] = 8'h42;
    add_frame();
    base = byte_q.size();
    s0   = start_count;
    pulse_refresh();
    wait_starts(s0 + 6, ok);
    for (int i = 0; i < BOUND && ok; i++) begin
      @(negedge CLK1K);
      if (LCD_DONE) break;
    end
    // DONE just rose for step 9: the next cycle is the LOAD of step 10
    @(posedge CLK1K); #1;
    WR_EN = 1'b1; WR_ADDR = 5'd5; WR_CHAR = 8'h42;
    @(posedge CLK1K); #1;
    WR_ADDR = 5'd30; WR_CHAR = c30;
    @(posedge CLK1K); #1;
    WR_EN = 1'b0;
    wait_frames(1, ok);
    pulse_refresh();
    if (ok) wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL coll_timeout: got no FRAME_DONE required two redraws"); end
    repeat (2) @(negedge CLK1K);
    checks++;
    if (byte_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL coll_byte_count: got %0d required %0d", byte_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= byte_q.size() || byte_q[base + i] !== exp_q[i]) begin
        failures++;
        $display("FAIL coll_byte%0d: got rs_data=%h required %h", i,
                 (base + i < byte_q.size()) ? byte_q[base + i] : 9'h000, exp_q[i]);
      end
    end
  endtask

  task automatic test_handshake();
    int base, sv0, dv0;
    bit ok;
    lat_min = 2; lat_max = 6; stale_cycles = 3;
    random_writes(4);
    exp_q.delete();
    add_frame();
    base = byte_q.size();
    sv0  = start_viol;
    dv0  = din_viol;
    pulse_refresh();
    wait_frames(1, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL hs_timeout: got no FRAME_DONE required one"); end
    repeat (2) @(negedge CLK1K);
    stale_cycles = 0;
    checks++;
    if (start_viol != sv0) begin failures++; $display("FAIL hs_start_width: got %0d bad START samples required 0", start_viol - sv0); end
    checks++;
    if (din_viol != dv0) begin failures++; $display("FAIL hs_din_stable: got %0d changes while busy required 0", din_viol - dv0); end
    checks++;
    if (byte_q.size() - base != exp_q.size()) begin
      failures++; $display("FAIL hs_byte_count: got %0d required %0d", byte_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      checks++;
      if (base + i >= byte_q.size() || byte_q[base + i] !== exp_q[i]) begin
        failures++;
        $display("FAIL hs_byte%0d: got rs_data=%h required %h", i,
                 (base + i < byte_q.size()) ? byte_q[base + i] : 9'h000, exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int s0, fd0;
    bit ok;
    lat_min = 3; lat_max = 5;
    random_writes(5);
    s0 = start_count;
    pulse_refresh();
    wait_starts(s0 + 12, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL mid_timeout: got %0d bytes required 12", start_count - s0); end
    #2 RSTN = 1'b0;
    #1;
    checks++;
    if ({LCD_DIN, LCD_RSO, LCD_START, READY, FRAME_DONE} !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got din=%h rs=%b start=%b ready=%b fd=%b required all 0",
               LCD_DIN, LCD_RSO, LCD_START, READY, FRAME_DONE);
    end
    fd0 = fd_count;
    repeat (3) @(negedge CLK1K);
    checks++;
    if (fd_count != fd0) begin failures++; $display("FAIL mid_no_frame_done: got %0d pulses required 0", fd_count - fd0); end
    for (int i = 0; i < 32; i++) ref_buf[i] = 8'h20;
    test_init();
  endtask

  initial begin
    test_reset();
    test_init();
    test_write_refresh();
    test_pending();
    test_collision();
    test_handshake();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
